// File: rtl/apb_cmd_master_if.sv
// APB bus bundle used between apb_cmd_master and an APB slave.
//
// Signals:
//   PADDR   - transfer address (master -> slave)
//   PWDATA  - write data (master -> slave)
//   PWRITE  - 1 = write, 0 = read (master -> slave)
//   PSEL    - slave select (master -> slave)
//   PENABLE - access phase marker (master -> slave)
//   PRDATA  - read data (slave -> master)
//   PREADY  - transfer completion (slave -> master)
//   PSLVERR - slave error flag (slave -> master)
//
// Modports: master (drives request side), slave (drives response side).
interface apb_cmd_master_if #(
   parameter int APB_ADDR_WIDTH = 12
);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a simple request/grant command port into single
// APB transfers and returns one response strobe per completed transfer.
//
// Ports:
//   HCLK, HRESETn  - clock, asynchronous active-low reset
//   req_i          - command request
//   addr_i         - target address
//   wdata_i        - write data
//   we_i           - 1 = write, 0 = read
//   gnt_o          - command accepted (combinational, IDLE only)
//   rsp_valid_o    - one-cycle response strobe
//   rsp_rdata_o    - read data (0 for writes), held until next response
//   rsp_err_o      - slave error or timeout, held until next response
//   busy_o         - transfer in progress
//   apb            - APB master modport (PADDR/PWDATA/PWRITE/PSEL/PENABLE
//                    out, PRDATA/PREADY/PSLVERR in)
//
// Optional feature: define APB_CMD_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles without PREADY (error response, data
// 32'hDEADBEEF). Without the macro the ACCESS phase waits forever.
module apb_cmd_master #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]               wdata_i,
   input  logic                      we_i,
   output logic                      gnt_o,
   output logic                      rsp_valid_o,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      busy_o,
   apb_cmd_master_if.master          apb
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]                state;
   logic [APB_ADDR_WIDTH-1:0] paddr;
   logic [31:0]               pwdata;
   logic                      pwrite;
   logic                      psel;
   logic                      penable;

`ifdef APB_CMD_TIMEOUT_EN
   // At least 8 bits, wider if the limit needs it.
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   assign gnt_o       = (state == IDLE) && req_i;
   assign busy_o      = (state != IDLE);
   assign rsp_valid_o = (state == RESP);

   assign apb.PADDR   = paddr;
   assign apb.PWDATA  = pwdata;
   assign apb.PWRITE  = pwrite;
   assign apb.PSEL    = psel;
   assign apb.PENABLE = penable;

   // Transfer sequencer. All APB outputs come straight from registers, so
   // PSEL/PENABLE are set one state ahead of the phase they mark. A reset
   // in any state drops the bus and discards the transfer silently.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         paddr       <= '0;
         pwdata      <= '0;
         pwrite      <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
`ifdef APB_CMD_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_i) begin
                  paddr  <= addr_i;
                  pwdata <= wdata_i;
                  pwrite <= we_i;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
`ifdef APB_CMD_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state   <= ACCESS;
            end
            ACCESS: begin
               // PREADY is tested first so a completion always beats the
               // timeout in the same cycle.
               if (apb.PREADY) begin
                  rsp_rdata_o <= pwrite ? 32'h0 : apb.PRDATA;
                  rsp_err_o   <= apb.PSLVERR;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= RESP;
               end
`ifdef APB_CMD_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  // This stalled cycle brings the count to TIMEOUT_CYCLES.
                  wait_cnt    <= wait_cnt + 1'b1;
                  rsp_rdata_o <= 32'hDEADBEEF;
                  rsp_err_o   <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: random and directed commands against a
// responding APB slave model; expected responses go into a scoreboard queue
// and a separate monitor compares them whenever rsp_valid_o is seen.
// Honours APB_CMD_TIMEOUT_EN the same way the design does.
module tb_apb_cmd_master;

   localparam int AW     = 12;
   localparam int TO_CYC = 4;
`ifdef APB_CMD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          we;
      int unsigned   waits;
      logic          err;
      logic [31:0]   rdata;
      int unsigned   gcyc;
   } cmd_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int unsigned at_cycle;
   } exp_t;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          req_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [31:0]   wdata_i = '0;
   logic          we_i = 1'b0;
   logic          gnt_o;
   logic          rsp_valid_o;
   logic [31:0]   rsp_rdata_o;
   logic          rsp_err_o;
   logic          busy_o;

   apb_cmd_master_if #(.APB_ADDR_WIDTH(AW)) apb ();

   apb_cmd_master #(
      .APB_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .req_i       (req_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .we_i        (we_i),
      .gnt_o       (gnt_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .apb         (apb)
   );

   always #5 HCLK = ~HCLK;

   int unsigned cycle = 0;
   always @(posedge HCLK) cycle <= cycle + 1;

   cmd_t        slave_q[$];
   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int unsigned last_rsp_cycle = 0;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // Expected response straight from the transfer rules: a slave that needs
   // 'waits' stalled cycles completes at grant+3+waits; with the timeout
   // built in, TO_CYC stalls end the transfer at grant+2+TO_CYC instead.
   function automatic exp_t refModel(input cmd_t c);
      exp_t e;
      if (TO_EN && c.waits >= TO_CYC) begin
         e.rdata    = 32'hDEADBEEF;
         e.err      = 1'b1;
         e.at_cycle = c.gcyc + 2 + TO_CYC;
      end else begin
         e.rdata    = c.we ? 32'h0 : c.rdata;
         e.err      = c.err;
         e.at_cycle = c.gcyc + 3 + c.waits;
      end
      return e;
   endfunction

   // Slave model: pops the next command when an access phase begins, holds
   // PREADY low for 'waits' cycles, checks the bus stays stable meanwhile.
   initial begin
      int   acnt;
      bit   have;
      cmd_t cur;
      acnt = 0;
      have = 1'b0;
      cur  = '0;
      apb.PREADY  = 1'b0;
      apb.PRDATA  = '0;
      apb.PSLVERR = 1'b0;
      forever begin
         @(negedge HCLK);
         if (apb.PSEL && apb.PENABLE) begin
            if (!have) begin
               if (slave_q.size() == 0) begin
                  checkOutput("unexpected_access", 64'd1, 64'd0);
                  cur = '0;
               end else begin
                  cur = slave_q.pop_front();
                  checkOutput("access_cycle", 64'(cycle), 64'(cur.gcyc + 2));
               end
               have = 1'b1;
               acnt = 0;
            end
            checkOutput("paddr_stable", 64'(apb.PADDR), 64'(cur.addr));
            checkOutput("pwdata_stable", 64'(apb.PWDATA), 64'(cur.wdata));
            checkOutput("pwrite_stable", 64'(apb.PWRITE), 64'(cur.we));
            if (acnt == int'(cur.waits)) begin
               apb.PREADY  = 1'b1;
               apb.PRDATA  = cur.rdata;
               apb.PSLVERR = cur.err;
            end else begin
               apb.PREADY  = 1'b0;
               apb.PRDATA  = $urandom;
               apb.PSLVERR = 1'($urandom_range(0, 1));
            end
            acnt++;
         end else begin
            have        = 1'b0;
            apb.PREADY  = 1'b0;
            apb.PSLVERR = 1'b0;
            apb.PRDATA  = $urandom;
         end
      end
   end

   // Monitor: compares each response strobe against the scoreboard and
   // checks response fields hold between strobes.
   initial begin
      exp_t        e;
      bit          seen;
      logic [31:0] held_rdata;
      logic        held_err;
      seen = 1'b0;
      held_rdata = '0;
      held_err = 1'b0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            seen = 1'b0;
         end else if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
               checkOutput("rsp_err", 64'(rsp_err_o), 64'(e.err));
               checkOutput("rsp_cycle", 64'(cycle), 64'(e.at_cycle));
               checkOutput("rsp_psel", 64'(apb.PSEL), 64'd0);
            end
            last_rsp_cycle = cycle;
            held_rdata = rsp_rdata_o;
            held_err = rsp_err_o;
            seen = 1'b1;
         end else if (seen) begin
            checkOutput("rsp_rdata_hold", 64'(rsp_rdata_o), 64'(held_rdata));
            checkOutput("rsp_err_hold", 64'(rsp_err_o), 64'(held_err));
         end
      end
   end

   // Presents one command, waits (bounded) for the grant, records the
   // expectation and checks the SETUP phase. Returns just after SETUP.
   task automatic applyStimulus(input cmd_t c_in, input bit keep_req, input bit chained);
      cmd_t c;
      bit   got;
      c = c_in;
      addr_i  = c.addr;
      wdata_i = c.wdata;
      we_i    = c.we;
      req_i   = 1'b1;
      got = 1'b0;
      for (int guard = 0; guard < 400 && !got; guard++) begin
         #1;
         if (busy_o) checkOutput("gnt_while_busy", 64'(gnt_o), 64'd0);
         if (gnt_o && !busy_o) got = 1'b1;
         else @(negedge HCLK);
      end
      if (!got) begin
         checkOutput("grant_timeout", 64'd0, 64'd1);
         req_i = 1'b0;
         return;
      end
      c.gcyc = cycle;
      if (chained) checkOutput("b2b_grant_cycle", 64'(c.gcyc), 64'(last_rsp_cycle + 1));
      slave_q.push_back(c);
      exp_q.push_back(refModel(c));
      @(negedge HCLK);
      if (!keep_req) req_i = 1'b0;
      #1;
      checkOutput("setup_psel", 64'(apb.PSEL), 64'd1);
      checkOutput("setup_penable", 64'(apb.PENABLE), 64'd0);
      checkOutput("setup_busy", 64'(busy_o), 64'd1);
      checkOutput("setup_paddr", 64'(apb.PADDR), 64'(c.addr));
      checkOutput("setup_pwrite", 64'(apb.PWRITE), 64'(c.we));
   endtask

   function automatic cmd_t mkCmd(input logic [AW-1:0] a, input logic [31:0] wd, input logic we,
                                  input int unsigned waits, input logic err, input logic [31:0] rd);
      cmd_t c;
      c.addr = a; c.wdata = wd; c.we = we; c.waits = waits;
      c.err = err; c.rdata = rd; c.gcyc = 0;
      return c;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got hang, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cmd_t c;
      bit   prev_keep;
      bit   keep;

      // Reset state.
      repeat (2) @(negedge HCLK);
      #1;
      checkOutput("rst_psel", 64'(apb.PSEL), 64'd0);
      checkOutput("rst_penable", 64'(apb.PENABLE), 64'd0);
      checkOutput("rst_pwrite", 64'(apb.PWRITE), 64'd0);
      checkOutput("rst_paddr", 64'(apb.PADDR), 64'd0);
      checkOutput("rst_pwdata", 64'(apb.PWDATA), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      checkOutput("rst_rsp_err", 64'(rsp_err_o), 64'd0);
      checkOutput("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      #2 HRESETn = 1'b1;
      @(negedge HCLK);

      $display("[TB] directed transfers");
      applyStimulus(mkCmd(12'h004, 32'h1A000100, 1'b1, 0, 1'b0, 32'h0), 1'b0, 1'b0);
      applyStimulus(mkCmd(12'h0A0, 32'h0, 1'b0, 3, 1'b0, 32'hCAFE0001), 1'b0, 1'b0);
      applyStimulus(mkCmd(12'h0B4, 32'h0, 1'b0, 1, 1'b1, 32'hDEADBEEF), 1'b0, 1'b0);
      // Timeout boundary: one stall short of the limit, then exactly at it.
      applyStimulus(mkCmd(12'h010, 32'h0, 1'b0, TO_CYC - 1, 1'b0, 32'h12345678), 1'b0, 1'b0);
      applyStimulus(mkCmd(12'h014, 32'h55AA55AA, 1'b1, TO_CYC, 1'b0, 32'h0), 1'b0, 1'b0);

      $display("[TB] back-to-back with req held");
      applyStimulus(mkCmd(12'h020, 32'h11111111, 1'b1, 0, 1'b0, 32'h0), 1'b1, 1'b0);
      applyStimulus(mkCmd(12'h024, 32'h0, 1'b0, 2, 1'b0, 32'hA5A50F0F), 1'b0, 1'b1);

      $display("[TB] slave never ready");
`ifdef APB_CMD_TIMEOUT_EN
      applyStimulus(mkCmd(12'h030, 32'h0, 1'b0, 1000, 1'b0, 32'h0), 1'b0, 1'b0);
      repeat (TO_CYC) @(negedge HCLK);
      #1 checkOutput("to_psel_last_access", 64'(apb.PSEL), 64'd1);
      @(negedge HCLK);
      #1 checkOutput("to_psel_dropped", 64'(apb.PSEL), 64'd0);
`else
      applyStimulus(mkCmd(12'h030, 32'h0, 1'b0, 105, 1'b0, 32'h0BADF00D), 1'b0, 1'b0);
      repeat (100) @(negedge HCLK);
      #1 checkOutput("stall_psel_held", 64'(apb.PSEL), 64'd1);
      checkOutput("stall_penable_held", 64'(apb.PENABLE), 64'd1);
`endif

      $display("[TB] reset during access");
      applyStimulus(mkCmd(12'h040, 32'h0, 1'b0, 20, 1'b0, 32'h0), 1'b0, 1'b0);
      @(negedge HCLK);
      #3 HRESETn = 1'b0;
      #1;
      checkOutput("abort_psel", 64'(apb.PSEL), 64'd0);
      checkOutput("abort_penable", 64'(apb.PENABLE), 64'd0);
      checkOutput("abort_busy", 64'(busy_o), 64'd0);
      checkOutput("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
      exp_q.delete();
      slave_q.delete();
      repeat (3) @(negedge HCLK);
      #3 HRESETn = 1'b1;
      @(negedge HCLK);
      applyStimulus(mkCmd(12'h044, 32'h0, 1'b0, 1, 1'b0, 32'h600DD00D), 1'b0, 1'b0);

      $display("[TB] random transfers");
      prev_keep = 1'b0;
      for (int i = 0; i < 40; i++) begin
         c = mkCmd(AW'($urandom), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, TO_CYC + 1), ($urandom_range(0, 3) == 0), $urandom);
         keep = (i != 39) && ($urandom_range(0, 1) == 1);
         applyStimulus(c, keep, prev_keep);
         prev_keep = keep;
      end

      // Drain outstanding responses.
      for (int guard = 0; guard < 300 && exp_q.size() != 0; guard++) @(negedge HCLK);
      checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge HCLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase cycles without PREADY (used only with APB_CMD_TIMEOUT_EN).
REQ-003 SHALL have one clock and an asynchronous active-low reset: HCLK  in  1  clock; HRESETn  in  1  async active-low reset.
REQ-004 Command ports SHALL be: req_i  in  1  command request; addr_i  in  APB_ADDR_WIDTH  target address; wdata_i  in  32  write data; we_i  in  1  1=write, 0=read; gnt_o  out  1  command accepted.
REQ-005 Response ports SHALL be: rsp_valid_o  out  1  one-cycle response strobe; rsp_rdata_o  out  32  read data; rsp_err_o  out  1  slave error or timeout; busy_o  out  1  transfer in progress.
REQ-006 APB ports SHALL be: PADDR  out  APB_ADDR_WIDTH; PWDATA  out  32; PWRITE  out  1; PSEL  out  1; PENABLE  out  1; PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-008 gnt_o SHALL be combinational, high only when state=IDLE and req_i=1.
REQ-009 On a grant, addr_i/wdata_i/we_i SHALL be captured into PADDR/PWDATA/PWRITE and the FSM SHALL go to SETUP.
REQ-010 SETUP: PSEL=1, PENABLE=0, lasting exactly one cycle, then ACCESS.
REQ-011 ACCESS: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE SHALL stay stable until PREADY=1 is sampled.
REQ-012 On PREADY=1 in ACCESS: rsp_rdata_o <= PRDATA for reads, 32'h0 for writes; rsp_err_o <= PSLVERR; PSEL/PENABLE <= 0; go to RESP.
REQ-013 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; no backpressure on the response.
REQ-014 rsp_rdata_o/rsp_err_o SHALL hold their value until the next response is written.
REQ-015 busy_o SHALL be 1 in SETUP, ACCESS and RESP; 0 in IDLE.
REQ-016 A req_i held while busy SHALL be ignored (gnt_o=0) and granted on the first IDLE cycle; back-to-back transfers therefore have one IDLE cycle between them.
REQ-017 Zero-wait latency: grant at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid_o cycle 3; each wait state adds one cycle.
REQ-018 PADDR/PWDATA/PWRITE SHALL hold their last values in IDLE; all APB outputs SHALL be registered.

Reset
REQ-019 On HRESETn=0: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o = 0; timeout counter = 0.
REQ-020 Reset asserted mid-transfer SHALL abort it immediately without emitting a response; after release the block SHALL accept a new command normally.

Configuration
REQ-021 Macro APB_CMD_TIMEOUT_EN SHALL gate the ACCESS-phase timeout.
REQ-022 With APB_CMD_TIMEOUT_EN defined: an 8-bit+ counter cleared on entering ACCESS SHALL increment each ACCESS cycle with PREADY=0; reaching TIMEOUT_CYCLES SHALL drop PSEL/PENABLE, set rsp_err_o=1 and rsp_rdata_o=32'hDEADBEEF, and go to RESP.
REQ-023 A PREADY=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal completion).
REQ-024 Without APB_CMD_TIMEOUT_EN: no counter; ACCESS waits indefinitely for PREADY.

Verification
REQ-025 Write addr 0x004, wdata 0x1A000100, zero-wait slave -> PSEL at cycle 1, PENABLE at cycle 2, rsp_valid_o at cycle 3, rsp_err_o=0, rsp_rdata_o=0.
REQ-026 Read addr 0x0A0, slave gives 3 wait states then PRDATA=0xCAFE0001 -> PADDR stable through ACCESS, rsp_valid_o at cycle 6, rsp_rdata_o=0xCAFE0001.
REQ-027 Read with PSLVERR=1, PRDATA=0xDEADBEEF on completion -> rsp_err_o=1, rsp_rdata_o=0xDEADBEEF.
REQ-028 With APB_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never ready -> PSEL drops after 4 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0xDEADBEEF; without the macro, PSEL stays high for 100 cycles.
REQ-029 req_i held high for two commands -> second gnt_o occurs only after rsp_valid_o plus one IDLE cycle.
REQ-030 HRESETn pulsed low in ACCESS -> PSEL=PENABLE=0 at once, no rsp_valid_o, next command completes normally.
